// File: rtl/dff_pipe_reg.sv
// Elastic WIDTH-bit, DEPTH-stage register pipeline with valid/ready on both sides,
// bubble collapsing, synchronous flush, occupancy count and a programmable reset value.
module dff_pipe_reg #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // valid never depends on ready, and in_ready is low during flush and reset.

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             run;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance when some stage at or beyond it is empty, or the output drains.
  always_comb begin
    adv = '0;
    run = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      run    = run | ~vld_q[i];
      adv[i] = run;
    end
  end

  assign in_ready  = adv[0] & ~flush & reset;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = in_xfer;
    src_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i]  = vld_q[i-1];
      src_data[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VALUE;
    end else if (flush) begin
      vld_q <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          vld_q[i] <= src_vld[i];
          // Data only moves with a valid item so an empty output stage keeps its last value.
          if (src_vld[i]) data_q[i] <= src_data[i];
        end
      end
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_dff_pipe_reg.sv
// Bench for dff_pipe_reg: item/position model of the pipeline compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dff_pipe_reg;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'hA5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;

  int errors = 0;
  int checks = 0;

  dff_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard/model: accepted items in FIFO order with their current stage index.
  logic [WIDTH-1:0] exp_q[$];
  int               pos_q[$];
  int               np[$];
  logic [WIDTH-1:0] m_last = RV;

  always @(negedge reset) begin
    exp_q.delete();
    pos_q.delete();
    m_last = RV;
  end

  always @(negedge clk) begin
    bit ov, ox, ir;
    int lim, n;
    if (!reset) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 32'(RV));
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
    end else begin
      ov = (exp_q.size() > 0) && (pos_q[0] == DEPTH-1);
      ox = ov && out_ready;
      // Items move one stage forward when the slot ahead is free after the items ahead moved.
      np.delete();
      lim = DEPTH-1;
      for (int i = (ox ? 1 : 0); i < pos_q.size(); i++) begin
        n = (pos_q[i] < lim) ? pos_q[i] + 1 : pos_q[i];
        np.push_back(n);
        lim = n - 1;
      end
      ir = (lim >= 0) && !flush;
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("out_data", 32'(out_data), 32'(m_last));
      chk("count", 32'(count), exp_q.size());
      chk("in_ready", 32'(in_ready), 32'(ir));
      if (flush) begin
        exp_q.delete();
        pos_q.delete();
        m_last = RV;
      end else begin
        if (ox) void'(exp_q.pop_front());
        pos_q = np;
        if (in_valid && ir) begin
          exp_q.push_back(in_data);
          pos_q.push_back(0);
        end
        if (exp_q.size() > 0 && pos_q[0] == DEPTH-1) m_last = exp_q[0];
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bit ok, done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  initial begin
    // Power-up reset
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_data", 32'(out_data), 32'(RV));
    chk("init_in_ready", 32'(in_ready), 0);
    reset = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    tick();

    // Streaming latency: presented before edge k, visible after edge k+3
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h98; tick();
    in_data   = 8'h67; tick();
    in_data   = 8'h01; tick();
    in_valid  = 1'b0;
    chk("stream_not_yet", 32'(out_valid), 0);
    tick();
    chk("stream_v0", 32'(out_valid), 1);
    chk("stream_d0", 32'(out_data), 32'h98);
    tick();
    chk("stream_d1", 32'(out_data), 32'h67);
    tick();
    chk("stream_d2", 32'(out_data), 32'h01);
    tick();
    chk("stream_empty_v", 32'(out_valid), 0);
    chk("stream_empty_d", 32'(out_data), 32'h01);
    drain();

    // Backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    in_valid = 1'b1;
    in_data  = 8'h05;
    tick(); tick();
    chk("bp_count", 32'(count), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_full_ready", 32'(in_ready), 1);
    chk("bp_d1", 32'(out_data), 32'h01);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      chk("bp_order", 32'(out_data), i);
      tick();
    end
    chk("bp_drained", 32'(out_valid), 0);
    drain();

    // Bubble collapse
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h11; tick();
    in_valid  = 1'b0; tick(); tick();
    in_valid  = 1'b1; in_data = 8'h22; tick();
    in_valid  = 1'b0;
    repeat (4) tick();
    chk("bub_count", 32'(count), 2);
    chk("bub_head", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    chk("bub_second_v", 32'(out_valid), 1);
    chk("bub_second_d", 32'(out_data), 32'h22);
    tick();
    chk("bub_empty", 32'(out_valid), 0);
    drain();

    // Flush
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'h31; tick();
    in_data = 8'h32; tick();
    in_data = 8'h33; tick();
    chk("fl_count_before", 32'(count), 3);
    flush   = 1'b1;
    in_data = 8'hEE;
    #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_count", 32'(count), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_out_data", 32'(out_data), 32'(RV));
    drain();

    // Full with simultaneous in/out
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h41 + 8'(i);
      tick();
    end
    chk("full_count", 32'(count), 4);
    chk("full_blocked", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_data = 8'h50 + 8'(j);
      #1;
      chk("full_in_ready", 32'(in_ready), 1);
      tick();
      chk("full_count_hold", 32'(count), 4);
      if (j == 0) chk("full_next_head", 32'(out_data), 32'h42);
    end
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'h61; tick();
    in_data = 8'h62; tick();
    in_data = 8'h63; tick();
    in_valid = 1'b0;
    chk("mr_count_before", 32'(count), 3);
    reset = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_out_data", 32'(out_data), 32'(RV));
    chk("mr_count", 32'(count), 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("mr_release_ready", 32'(in_ready), 1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
